// File: rtl/exu_brstat_ctl_if.sv
// Branch-stat controller port bundle: per-pipe resolve events, clear request, req/ack read port.
// The master drives events and requests; the slave (controller) returns busy, ack, data and sat flags.
interface exu_brstat_ctl_if #(
    parameter int CNT_W   = 32,
    parameter int NUM_CNT = 6
);
    logic               freeze;
    logic               flush;
    logic               i0_valid;
    logic               i0_pred_t;
    logic               i0_pred_nt;
    logic               i0_flush_upper;
    logic               i0_cond_misp;
    logic               i1_valid;
    logic               i1_pred_t;
    logic               i1_pred_nt;
    logic               i1_flush_upper;
    logic               i1_cond_misp;
    logic               clr_req;
    logic               clr_busy;
    logic               rd_req;
    logic [2:0]         rd_idx;
    logic               rd_ack;
    logic [CNT_W-1:0]   rd_data;
    logic [NUM_CNT-1:0] sat;

    modport master (
        output freeze, flush,
        output i0_valid, i0_pred_t, i0_pred_nt, i0_flush_upper, i0_cond_misp,
        output i1_valid, i1_pred_t, i1_pred_nt, i1_flush_upper, i1_cond_misp,
        output clr_req, rd_req, rd_idx,
        input  clr_busy, rd_ack, rd_data, sat
    );

    modport slave (
        input  freeze, flush,
        input  i0_valid, i0_pred_t, i0_pred_nt, i0_flush_upper, i0_cond_misp,
        input  i1_valid, i1_pred_t, i1_pred_nt, i1_flush_upper, i1_cond_misp,
        input  clr_req, rd_req, rd_idx,
        output clr_busy, rd_ack, rd_data, sat
    );
endinterface

// File: rtl/exu_brstat_ctl.sv
// Saturating branch-resolution counters for ALU pipes i0/i1 (i1 built only with RV_BRSTAT_I1_EN).
// Counters update every edge; rd_ack one cycle after rd_req is accepted; a clear walk holds off reads.
module exu_brstat_ctl #(
    parameter int CNT_W   = 32,
    parameter int NUM_CNT = 6
) (
    input  logic            clk,
    input  logic            rst_l,
    exu_brstat_ctl_if.slave bus
);

    typedef enum logic [1:0] {IDLE, CLEAR, READ} state_t;

    state_t             state_q, state_d;
    logic [2:0]         ptr_q, ptr_d;
    logic               clr_busy, rd_ack, rd_take;
    logic [CNT_W-1:0]   cnt     [NUM_CNT];
    logic [CNT_W:0]     sum     [NUM_CNT];
    logic [1:0]         inc     [NUM_CNT];
    logic [NUM_CNT-1:0] sat_q;
    logic [CNT_W-1:0]   rd_data_q, rd_sel;
    logic               q0, q1;
    logic               i1_fu, i1_cm, i1_pt, i1_pnt;

    assign q0 = bus.i0_valid & (bus.i0_pred_t | bus.i0_pred_nt) & ~bus.flush & ~bus.freeze;

`ifdef RV_BRSTAT_I1_EN
    // A redirect on the older op squashes the younger one in the same cycle.
    assign q1 = bus.i1_valid & (bus.i1_pred_t | bus.i1_pred_nt) & ~bus.flush & ~bus.freeze
              & ~(q0 & bus.i0_flush_upper);
    assign i1_fu  = bus.i1_flush_upper;
    assign i1_cm  = bus.i1_cond_misp;
    assign i1_pt  = bus.i1_pred_t;
    assign i1_pnt = bus.i1_pred_nt;
`else
    logic unused_i1;
    assign unused_i1 = ^{bus.i1_valid, bus.i1_pred_t, bus.i1_pred_nt,
                         bus.i1_flush_upper, bus.i1_cond_misp};
    assign q1     = 1'b0;
    assign i1_fu  = 1'b0;
    assign i1_cm  = 1'b0;
    assign i1_pt  = 1'b0;
    assign i1_pnt = 1'b0;
`endif

    always_comb begin
        for (int i = 0; i < NUM_CNT; i++) inc[i] = 2'b00;
        inc[0] = 2'(q0) + 2'(q1);
        inc[1] = 2'(q0 & ~bus.i0_flush_upper) + 2'(q1 & ~i1_fu);
        inc[2] = 2'(q0 &  bus.i0_flush_upper) + 2'(q1 &  i1_fu);
        inc[3] = 2'(q0 &  bus.i0_cond_misp)   + 2'(q1 &  i1_cm);
        inc[4] = 2'(q0 &  bus.i0_pred_t)      + 2'(q1 &  i1_pt);
        inc[5] = 2'(q0 &  bus.i0_pred_nt)     + 2'(q1 &  i1_pnt);
        for (int i = 0; i < NUM_CNT; i++) sum[i] = {1'b0, cnt[i]} + (CNT_W+1)'(inc[i]);
    end

    // Unmapped indices fall through to zero.
    always_comb begin
        rd_sel = '0;
        for (int i = 0; i < NUM_CNT; i++) begin
            if (bus.rd_idx == 3'(i)) rd_sel = cnt[i];
        end
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        clr_busy = 1'b0;
        rd_ack   = 1'b0;
        rd_take  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.clr_req) begin
                    state_d = CLEAR;
                    ptr_d   = 3'd0;
                end else if (bus.rd_req) begin
                    state_d = READ;
                    rd_take = 1'b1;
                end
            end
            CLEAR: begin
                clr_busy = 1'b1;
                if (ptr_q == 3'(NUM_CNT-1)) begin
                    state_d = IDLE;
                    ptr_d   = 3'd0;
                end else begin
                    ptr_d = ptr_q + 3'd1;
                end
            end
            READ: begin
                rd_ack  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_l) begin
            state_q   <= IDLE;
            ptr_q     <= 3'd0;
            rd_data_q <= '0;
            sat_q     <= '0;
            for (int i = 0; i < NUM_CNT; i++) cnt[i] <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            if (rd_take) rd_data_q <= rd_sel;
            for (int i = 0; i < NUM_CNT; i++) begin
                if (state_q == CLEAR && ptr_q == 3'(i)) begin
                    cnt[i]   <= '0;
                    sat_q[i] <= 1'b0;
                end else if (sum[i][CNT_W]) begin
                    cnt[i]   <= '1;
                    sat_q[i] <= 1'b1;
                end else begin
                    cnt[i] <= sum[i][CNT_W-1:0];
                end
            end
        end
    end

    assign bus.clr_busy = clr_busy;
    assign bus.rd_ack   = rd_ack;
    assign bus.rd_data  = rd_data_q;
    assign bus.sat      = sat_q;

endmodule

// File: tb/tb_exu_brstat_ctl.sv
// Directed bench for exu_brstat_ctl at CNT_W=8; read results are scoreboarded against queued expectations.
module tb_exu_brstat_ctl;

    localparam int CW = 8;
    localparam int NC = 6;
`ifdef RV_BRSTAT_I1_EN
    localparam int I1 = 1;
`else
    localparam int I1 = 0;
`endif
    localparam int R = 1 + I1;

    logic clk;
    logic rst_l;
    int   checks = 0;
    int   errors = 0;

    logic [CW-1:0] exp_q [$];
    string         tag_q [$];
    logic [CW-1:0] mon_exp;
    string         mon_tag;

    exu_brstat_ctl_if #(.CNT_W(CW), .NUM_CNT(NC)) bif ();

    exu_brstat_ctl #(.CNT_W(CW), .NUM_CNT(NC)) dut (
        .clk   (clk),
        .rst_l (rst_l),
        .bus   (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bif.rd_ack === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_ack", 32'(bif.rd_ack), 32'd0);
            end else begin
                mon_exp = exp_q.pop_front();
                mon_tag = tag_q.pop_front();
                check(mon_tag, 32'(bif.rd_data), 32'(mon_exp));
            end
        end
    end

    task automatic ev(input bit v0, pt0, pnt0, fu0, cm0, v1, pt1, pnt1, fu1, cm1);
        bif.i0_valid = v0; bif.i0_pred_t = pt0; bif.i0_pred_nt = pnt0;
        bif.i0_flush_upper = fu0; bif.i0_cond_misp = cm0;
        bif.i1_valid = v1; bif.i1_pred_t = pt1; bif.i1_pred_nt = pnt1;
        bif.i1_flush_upper = fu1; bif.i1_cond_misp = cm1;
    endtask

    task automatic idle();
        ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        bif.freeze = 1'b0;
        bif.flush  = 1'b0;
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Queues the expected value, raises rd_req (optionally with clr_req) and waits for the ack.
    task automatic do_read(input logic [2:0] idx, input int exp, input int exp_lat,
                           input bit with_clr, input string tag);
        int n;
        bit got;
        exp_q.push_back(CW'(exp));
        tag_q.push_back(tag);
        bif.rd_idx = idx;
        bif.rd_req = 1'b1;
        if (with_clr) bif.clr_req = 1'b1;
        n   = 0;
        got = 1'b0;
        while (!got && n < 40) begin
            @(negedge clk);
            bif.clr_req = 1'b0;
            if (with_clr && n < 6) check({tag, "_busy"}, 32'(bif.clr_busy), 32'd1);
            if (bif.rd_ack === 1'b1) got = 1'b1;
            else n++;
        end
        bif.rd_req = 1'b0;
        check({tag, "_acked"}, 32'(got), 32'd1);
        check({tag, "_latency"}, 32'(n), 32'(exp_lat));
        @(negedge clk);
        check({tag, "_ack_pulse"}, 32'(bif.rd_ack), 32'd0);
    endtask

    initial begin
        int busy;
        rst_l = 1'b0;
        bif.clr_req = 1'b0;
        bif.rd_req  = 1'b0;
        bif.rd_idx  = 3'd0;
        idle();
        tick(3);
        check("rst_clr_busy", 32'(bif.clr_busy), 32'd0);
        check("rst_rd_ack",   32'(bif.rd_ack),   32'd0);
        check("rst_rd_data",  32'(bif.rd_data),  32'd0);
        check("rst_sat",      32'(bif.sat),      32'd0);
        rst_l = 1'b1;
        tick(1);
        do_read(3'd3, 0, 0, 0, "rst_c3");

        // Ten taken, correctly predicted i0 branches.
        ev(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        tick(10);
        idle();
        do_read(3'd0, 10, 0, 0, "t2_c0");
        do_read(3'd1, 10, 0, 0, "t2_c1");
        do_read(3'd4, 10, 0, 0, "t2_c4");
        do_read(3'd2, 0,  0, 0, "t2_c2");

        // i0 redirect squashes i1, then the same pair without the redirect.
        ev(1, 1, 0, 1, 1, 1, 0, 1, 0, 0);
        tick(1);
        ev(1, 1, 0, 0, 0, 1, 0, 1, 0, 0);
        tick(1);
        idle();
        do_read(3'd0, 12 + I1, 0, 0, "t3_c0");
        do_read(3'd1, 11 + I1, 0, 0, "t3_c1");
        do_read(3'd2, 1,       0, 0, "t3_c2");
        do_read(3'd3, 1,       0, 0, "t3_c3");
        do_read(3'd5, I1,      0, 0, "t3_c5");
        do_read(3'd4, 12,      0, 0, "t3_c4");
        tick(3);
        check("t3_rd_data_hold", 32'(bif.rd_data), 32'd12);

        // Freeze and flush block all counting.
        ev(1, 1, 1, 1, 1, 1, 1, 1, 1, 1);
        bif.freeze = 1'b1;
        tick(3);
        bif.freeze = 1'b0;
        bif.flush  = 1'b1;
        tick(3);
        idle();
        do_read(3'd0, 12 + I1, 0, 0, "t4_c0");
        do_read(3'd2, 1,       0, 0, "t4_c2");
        do_read(3'd7, 0, 0, 0, "t5_idx7");
        do_read(3'd6, 0, 0, 0, "t5_idx6");

        // Read issued together with a clear waits out the walk.
        do_read(3'd0, 0, 7, 1, "t6_c0_after_clr");
        do_read(3'd4, 0, 0, 0, "t6_c4");

        // Clear while both pipes count every cycle for 12 edges.
        ev(1, 1, 1, 0, 0, 1, 1, 1, 0, 0);
        bif.clr_req = 1'b1;
        tick(1);
        bif.clr_req = 1'b0;
        tick(11);
        idle();
        check("t7_busy_done", 32'(bif.clr_busy), 32'd0);
        do_read(3'd0, R * 10, 0, 0, "t7_c0");
        do_read(3'd1, R * 9,  0, 0, "t7_c1");
        do_read(3'd4, R * 6,  0, 0, "t7_c4");
        do_read(3'd5, R * 5,  0, 0, "t7_c5");
        do_read(3'd2, 0,      0, 0, "t7_c2");

        // Saturation at 8 bits, then a clear.
        ev(1, 1, 0, 0, 0, 1, 1, 0, 0, 0);
        tick(300);
        idle();
        check("t8_sat", 32'(bif.sat), 32'b010011);
        do_read(3'd0, 255,   0, 0, "t8_c0_sat");
        do_read(3'd5, R * 5, 0, 0, "t8_c5");
        bif.clr_req = 1'b1;
        busy = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            bif.clr_req = 1'b0;
            if (bif.clr_busy === 1'b1) busy++;
        end
        check("t8_busy_cycles", 32'(busy), 32'd6);
        check("t8_sat_cleared", 32'(bif.sat), 32'd0);
        do_read(3'd0, 0, 0, 0, "t8_c0_clr");
        do_read(3'd5, 0, 0, 0, "t8_c5_clr");

        // Reset in the middle of a clear walk.
        ev(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        tick(260);
        idle();
        bif.clr_req = 1'b1;
        tick(1);
        bif.clr_req = 1'b0;
        tick(1);
        rst_l = 1'b0;
        tick(1);
        check("t9_busy_rst", 32'(bif.clr_busy), 32'd0);
        check("t9_sat_rst",  32'(bif.sat),      32'd0);
        rst_l = 1'b1;
        tick(1);
        check("t9_busy_after", 32'(bif.clr_busy), 32'd0);
        do_read(3'd4, 0, 0, 0, "t9_c4");
        do_read(3'd1, 0, 0, 0, "t9_c1");

        tick(2);
        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
